// File: rtl/result_scan_if.sv
// ----------------------------------------------------------------------------
// result_scan_if : start/board request and busy/done/result response bundle
// Optional macro RESULT_LINE_EN adds the winning-line index o_line. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface result_scan_if #(
   parameter int N = 3
);
   localparam int c_W = $clog2(2*N+2);

   logic                 i_start;
   logic [2*N*N-1:0]     i_board;
   logic                 o_busy;
   logic                 o_done;
   logic [1:0]           o_result;
`ifdef RESULT_LINE_EN
   logic [c_W-1:0]       o_line;
`endif

   modport master (
      output i_start, i_board,
`ifdef RESULT_LINE_EN
      input  o_line,
`endif
      input  o_busy, o_done, o_result
   );

   modport slave (
      input  i_start, i_board,
`ifdef RESULT_LINE_EN
      output o_line,
`endif
      output o_busy, o_done, o_result
   );
endinterface

`default_nettype wire

// File: rtl/result_scan.sv
// ----------------------------------------------------------------------------
// result_scan : sequential N x N win/draw evaluator, one line checked per clock
// Optional macro RESULT_LINE_EN enables the winning-line index output. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module result_scan #(
   parameter int N = 3
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   result_scan_if.slave  bus
);
   localparam int c_CELLS = N*N;
   localparam int c_LINES = 2*N+2;
   localparam int c_W     = $clog2(c_LINES);
   localparam logic [c_W-1:0] c_LAST = c_W'(c_LINES-1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SCAN = 1'b1
   } state_t;

   state_t               r_state;
   logic [c_W-1:0]       r_idx;
   logic [2*c_CELLS-1:0] r_board;
   logic                 r_busy;
   logic                 r_done;
   logic [1:0]           r_result;
`ifdef RESULT_LINE_EN
   logic [c_W-1:0]       r_line;
`endif

   logic [c_CELLS-1:0]   w_xc;
   logic [c_CELLS-1:0]   w_oc;
   logic [c_CELLS-1:0]   w_ec;
   logic [N-1:0]         w_lx [c_LINES];
   logic [N-1:0]         w_lo [c_LINES];
   logic [c_LINES-1:0]   w_xw;
   logic [c_LINES-1:0]   w_ow;
   logic                 w_x_hit;
   logic                 w_o_hit;
   logic                 w_any_empty;

   // Cell k = r*N+c lives at the MSB end for k=0; 2'b10 matches nobody.
   for (genvar k = 0; k < c_CELLS; k++) begin : g_cell
      assign w_xc[k] = (r_board[2*(c_CELLS-1-k) +: 2] == 2'b11);
      assign w_oc[k] = (r_board[2*(c_CELLS-1-k) +: 2] == 2'b01);
      assign w_ec[k] = (r_board[2*(c_CELLS-1-k) +: 2] == 2'b00);
   end

   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         assign w_lx[r][c]   = w_xc[r*N+c];
         assign w_lo[r][c]   = w_oc[r*N+c];
         assign w_lx[N+c][r] = w_xc[r*N+c];
         assign w_lo[N+c][r] = w_oc[r*N+c];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_diag
      assign w_lx[2*N][i]   = w_xc[i*N+i];
      assign w_lo[2*N][i]   = w_oc[i*N+i];
      assign w_lx[2*N+1][i] = w_xc[i*N+(N-1-i)];
      assign w_lo[2*N+1][i] = w_oc[i*N+(N-1-i)];
   end

   for (genvar l = 0; l < c_LINES; l++) begin : g_line
      assign w_xw[l] = &w_lx[l];
      assign w_ow[l] = &w_lo[l];
   end

   assign w_x_hit     = w_xw[r_idx];
   assign w_o_hit     = w_ow[r_idx];
   assign w_any_empty = |w_ec;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_board  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= 2'd0;
`ifdef RESULT_LINE_EN
         r_line   <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  r_board <= bus.i_board;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SCAN;
               end
            end
            S_SCAN: begin
               // Lowest-index winning line decides; X and O cannot share a line.
               if (w_x_hit || w_o_hit) begin
                  r_result <= w_x_hit ? 2'd1 : 2'd2;
`ifdef RESULT_LINE_EN
                  r_line   <= r_idx;
`endif
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= S_IDLE;
               end else if (r_idx == c_LAST) begin
                  r_result <= w_any_empty ? 2'd0 : 2'd3;
`ifdef RESULT_LINE_EN
                  r_line   <= '0;
`endif
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= S_IDLE;
               end else begin
                  r_idx <= r_idx + c_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_busy   = r_busy;
   assign bus.o_done   = r_done;
   assign bus.o_result = r_result;
`ifdef RESULT_LINE_EN
   assign bus.o_line   = r_line;
`endif

endmodule

`default_nettype wire

// File: tb/tb_result_scan.sv
// ----------------------------------------------------------------------------
// tb_result_scan : directed table-driven bench for result_scan (N=3 and N=4)
// Line-index checks are compiled in only with RESULT_LINE_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_result_scan;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   result_scan_if #(.N(3)) if3 ();
   result_scan_if #(.N(4)) if4 ();

   result_scan #(.N(3)) u_dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(if3));
   result_scan #(.N(4)) u_dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(if4));

   typedef struct {
      logic [17:0] board;
      logic [1:0]  res;
      int          line;
      int          edges;
   } vec_t;

   vec_t vecs[11];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Called at a negedge; starts a scan and returns at the negedge after done.
   task automatic eval3(input logic [17:0] b, input logic [1:0] er,
                        input int el, input int ee, input int id);
      int edges = 0;
      int busy_n = 0;
      bit seen = 0;
      string tag = $sformatf("vec%0d", id);
      if3.i_board = b;
      if3.i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if3.i_start = 1'b0;
      check({tag, "_done_clr"}, int'(if3.o_done), 0);
      while (!seen && edges < 40) begin
         if (if3.o_busy) busy_n++;
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (if3.o_done) seen = 1;
      end
      check({tag, "_done_seen"}, int'(seen), 1);
      check({tag, "_edges"}, edges, ee);
      check({tag, "_busy_cycles"}, busy_n, ee);
      check({tag, "_busy_low"}, int'(if3.o_busy), 0);
      check({tag, "_result"}, int'(if3.o_result), int'(er));
`ifdef RESULT_LINE_EN
      check({tag, "_line"}, int'(if3.o_line), el);
`else
      if (el < 0) $display("note: line %0d", el);
`endif
   endtask

   initial begin
      int  edges;
      bit  seen;
      bit  spurious;

      vecs[0]  = '{18'h3F000, 2'd1, 0, 1};   // X row 0
      vecs[1]  = '{18'h01110, 2'd2, 7, 8};   // O anti-diagonal
      vecs[2]  = '{18'h37D5F, 2'd3, 0, 8};   // full board, draw
      vecs[3]  = '{18'h00000, 2'd0, 0, 8};   // empty
      vecs[4]  = '{18'h27D5F, 2'd3, 0, 8};   // one invalid cell, rest full
      vecs[5]  = '{18'h3F015, 2'd1, 0, 1};   // X row 0 beats O row 2
      vecs[6]  = '{18'h00015, 2'd2, 2, 3};   // O row 2
      vecs[7]  = '{18'h10101, 2'd2, 6, 7};   // O main diagonal
      vecs[8]  = '{18'h2A000, 2'd0, 0, 8};   // invalid row is no win
      vecs[9]  = '{18'h0057F, 2'd2, 1, 2};   // O row 1 beats X row 2
      vecs[10] = '{18'h0C30C, 2'd1, 4, 5};   // X column 1

      if3.i_start = 1'b0;
      if3.i_board = '0;
      if4.i_start = 1'b0;
      if4.i_board = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", int'(if3.o_busy), 0);
      check("rst_done", int'(if3.o_done), 0);
      check("rst_result", int'(if3.o_result), 0);
`ifdef RESULT_LINE_EN
      check("rst_line", int'(if3.o_line), 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Consecutive entries start in the previous done cycle: back-to-back.
      for (int i = 0; i < 11; i++)
         eval3(vecs[i].board, vecs[i].res, vecs[i].line, vecs[i].edges, i);

      // Start and board change mid-scan must not disturb the latched board.
      @(negedge clk);
      if3.i_board = 18'h01110;
      if3.i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if3.i_start = 1'b0;
      if3.i_board = 18'h3F000;
      edges = 0;
      seen = 0;
      while (!seen && edges < 40) begin
         if (edges == 2) begin
            if3.i_start = 1'b1;
            check("mid_result_held", int'(if3.o_result), 1);
         end else begin
            if3.i_start = 1'b0;
         end
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (if3.o_done) seen = 1;
      end
      if3.i_start = 1'b0;
      check("mid_done_seen", int'(seen), 1);
      check("mid_edges", edges, 8);
      check("mid_result", int'(if3.o_result), 2);
`ifdef RESULT_LINE_EN
      check("mid_line", int'(if3.o_line), 7);
`endif
      @(posedge clk);
      @(negedge clk);
      check("done_pulse_one", int'(if3.o_done), 0);
      check("result_hold", int'(if3.o_result), 2);
      check("idle_not_busy", int'(if3.o_busy), 0);

      // Reset at scan edge 4 aborts silently.
      if3.i_board = 18'h37D5F;
      if3.i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if3.i_start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("pre_rst_busy", int'(if3.o_busy), 1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy", int'(if3.o_busy), 0);
      check("abort_done", int'(if3.o_done), 0);
      check("abort_result", int'(if3.o_result), 0);
`ifdef RESULT_LINE_EN
      check("abort_line", int'(if3.o_line), 0);
`endif
      rst_n = 1'b1;
      spurious = 0;
      repeat (12) begin
         @(posedge clk);
         @(negedge clk);
         if (if3.o_done || if3.o_busy) spurious = 1;
      end
      check("abort_quiet", int'(spurious), 0);

      // N=4, X main diagonal -> line 8.
      if4.i_board = 32'hC0300C03;
      if4.i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if4.i_start = 1'b0;
      check("n4_busy", int'(if4.o_busy), 1);
      edges = 0;
      seen = 0;
      while (!seen && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (if4.o_done) seen = 1;
      end
      check("n4_done_seen", int'(seen), 1);
      check("n4_edges", edges, 9);
      check("n4_result", int'(if4.o_result), 1);
`ifdef RESULT_LINE_EN
      check("n4_line", int'(if4.o_line), 8);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
